// File: rtl/Axis_IF.sv
// Axis_IF: AXI-stream style point-stream bundle used between the PWL DMA
// transmit end and the PWL waveform builder.
//
// Handshake: a beat transfers on every rising clk edge where valid and ready
// are both high. While valid is high and ready is low the source holds data
// and last unchanged and does not drop valid. ready may be held low
// indefinitely. done is a one-cycle pulse after the final beat of a run.
//
// Signals:
//   data  [DATA_WIDTH] source -> sink  beat payload
//   valid             source -> sink  payload present
//   ready             sink -> source  sink accepts payload
//   last              source -> sink  marks the final beat of a run
//   done              source -> sink  run completion pulse
interface Axis_IF #(
  parameter int DATA_WIDTH = 48
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic                  done;

  modport stream_out (output data, output valid, output last, output done, input ready);
  modport stream_in  (input data, input valid, input last, input done, output ready);
endinterface

// File: rtl/pwl_point_streamer.sv
// pwl_point_streamer: transmit end of the PWL DMA point stream.
//
// Host software writes (time, sample) breakpoints into a local table. On
// start the block walks the table, computes the slope of each segment with
// a sequential restoring divider and emits one beat {time, sample, slope}
// per breakpoint, followed by a one-cycle done pulse.
//
// Optional feature macro: PWL_ROUND_SLOPE_EN
//   defined     -> slope magnitude rounds half away from zero
//   not defined -> slope truncates toward zero
//   Latency is the same in both builds.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   halt          synchronous abort back to IDLE (err kept, no done)
//   pt_wr_*       breakpoint table write port (time unsigned, sample signed)
//   num_pts       number of points, latched when start is accepted
//   start         single-cycle launch pulse
//   busy          high from start acceptance until the run ends
//   err           sticky error; cleared by rst or the next accepted start
//   state_dbg     current FSM state encoding (IDLE=0 LOAD=1 DIVIDE=2 SEND=3 FIN=4)
//   dma           stream source: data[47:32]=time, [31:16]=sample, [15:0]=slope
module pwl_point_streamer #(
  parameter int DMA_DATA_WIDTH = 48,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int PT_DEPTH       = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        halt,
  input  logic                        pt_wr_en,
  input  logic [$clog2(PT_DEPTH)-1:0] pt_wr_addr,
  input  logic [SAMPLE_WIDTH-1:0]     pt_wr_time,
  input  logic [SAMPLE_WIDTH-1:0]     pt_wr_sample,
  input  logic [$clog2(PT_DEPTH):0]   num_pts,
  input  logic                        start,
  output logic                        busy,
  output logic                        err,
  output logic [2:0]                  state_dbg,
  Axis_IF.stream_out                  dma
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int AW = $clog2(PT_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(W);

  localparam logic [W:0]    POS_LIM = (W+1)'((1 << (W-1)) - 1);
  localparam logic [W:0]    NEG_LIM = (W+1)'(1 << (W-1));
  localparam logic [CW-1:0] CNT_END = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DIVIDE = 3'd2,
    S_SEND   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t state, state_n;

  // Breakpoint table (not reset)
  logic [W-1:0] t_mem [PT_DEPTH];
  logic [W-1:0] s_mem [PT_DEPTH];

  always_ff @(posedge clk) begin
    if (pt_wr_en) begin
      t_mem[pt_wr_addr] <= pt_wr_time;
      s_mem[pt_wr_addr] <= pt_wr_sample;
    end
  end

  // Run state
  logic [NW-1:0] npts_q;
  logic [AW-1:0] idx_q;
  logic [W-1:0]  time_q, sample_q, slope_q;
  logic [W-1:0]  dt_q, dvd_q, rem_q;
  logic          neg_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] idx_nx, last_idx;
  logic          is_last, order_bad, num_bad, accept, div_done;
  logic [W-1:0]  t0, t1, s0, s1, dt, ds_mag;
  logic [W:0]    ds;

  assign idx_nx    = idx_q + AW'(1);
  assign last_idx  = AW'(npts_q - NW'(1));
  assign is_last   = (idx_q == last_idx);
  assign t0        = t_mem[idx_q];
  assign t1        = t_mem[idx_nx];
  assign s0        = s_mem[idx_q];
  assign s1        = s_mem[idx_nx];
  assign order_bad = (t1 <= t0);
  assign dt        = t1 - t0;
  assign ds        = {s1[W-1], s1} - {s0[W-1], s0};
  assign ds_mag    = ds[W] ? W'(-ds) : ds[W-1:0];
  assign num_bad   = (num_pts < NW'(2)) || (num_pts > NW'(PT_DEPTH));
  // FIN already has busy low, so a start landing there is honoured too.
  assign accept    = (state == S_IDLE || state == S_FIN) && start && !halt;
  assign div_done  = (cnt_q == CNT_END);

  // One restoring-division step: dvd_q shifts out dividend bits at the top
  // and collects quotient bits at the bottom.
  logic [W:0]   rem_shift;
  logic         rem_ge;
  logic [W-1:0] rem_step, q_step;
  logic         round_up;
  logic [W:0]   mag;
  logic [W-1:0] slope_div;

  assign rem_shift = {rem_q, dvd_q[W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dt_q});
  // Without subtraction rem_shift is below dt, so its top bit is zero.
  assign rem_step  = rem_ge ? W'(rem_shift - {1'b0, dt_q}) : rem_shift[W-1:0];
  assign q_step    = {dvd_q[W-2:0], rem_ge};

`ifdef PWL_ROUND_SLOPE_EN
  assign round_up = ({rem_step, 1'b0} >= {1'b0, dt_q});
`else
  assign round_up = 1'b0;
`endif

  // Magnitude may reach 2^W after rounding; saturate after the sign.
  assign mag = {1'b0, q_step} + (W+1)'(round_up);

  always_comb begin
    slope_div = '0;
    if (neg_q) begin
      if (mag > NEG_LIM) slope_div = {1'b1, {(W-1){1'b0}}};
      else               slope_div = W'(-mag);
    end else begin
      if (mag > POS_LIM) slope_div = {1'b0, {(W-1){1'b1}}};
      else               slope_div = mag[W-1:0];
    end
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (halt) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (accept && !num_bad) state_n = S_LOAD;
          else                    state_n = S_IDLE;
        end
        // The final point has no successor entry, so its order check is skipped.
        S_LOAD: begin
          if (is_last)        state_n = S_SEND;
          else if (order_bad) state_n = S_IDLE;
          else                state_n = S_DIVIDE;
        end
        S_DIVIDE: if (div_done) state_n = S_SEND;
        S_SEND: begin
          if (dma.ready) state_n = is_last ? S_FIN : S_LOAD;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npts_q   <= '0;
      idx_q    <= '0;
      err      <= 1'b0;
      time_q   <= '0;
      sample_q <= '0;
      slope_q  <= '0;
      dt_q     <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (!halt) begin
      if (accept) begin
        npts_q <= num_pts;
        idx_q  <= '0;
        err    <= num_bad;
      end
      case (state)
        S_LOAD: begin
          time_q   <= t0;
          sample_q <= s0;
          dt_q     <= dt;
          neg_q    <= ds[W];
          dvd_q    <= ds_mag;
          rem_q    <= '0;
          cnt_q    <= '0;
          if (is_last)        slope_q <= '0;
          else if (order_bad) err     <= 1'b1;
        end
        S_DIVIDE: begin
          dvd_q <= q_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + CW'(1);
          if (div_done) slope_q <= slope_div;
        end
        S_SEND: begin
          if (dma.ready && !is_last) idx_q <= idx_nx;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so rst drops valid immediately.
  logic [DMA_DATA_WIDTH-1:0] beat;

  always_comb begin
    beat          = '0;
    beat[3*W-1:0] = {time_q, sample_q, slope_q};
  end

  assign dma.data  = beat;
  assign dma.valid = (state == S_SEND);
  assign dma.last  = (state == S_SEND) && is_last;
  assign dma.done  = (state == S_FIN);
  assign busy      = (state == S_LOAD) || (state == S_DIVIDE) || (state == S_SEND);
  assign state_dbg = state;

endmodule

// File: tb/tb_pwl_point_streamer.sv
// Directed testbench for pwl_point_streamer: table loads, slope arithmetic,
// back-pressure, ordering and count errors, halt and asynchronous reset.
module tb_pwl_point_streamer;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        halt, pt_wr_en, start, busy, err;
  logic [5:0]  pt_wr_addr;
  logic [15:0] pt_wr_time, pt_wr_sample;
  logic [6:0]  num_pts;
  logic [2:0]  state_dbg;

  Axis_IF #(.DATA_WIDTH(48)) dma_if ();

  pwl_point_streamer #(
    .DMA_DATA_WIDTH(48),
    .SAMPLE_WIDTH  (16),
    .PT_DEPTH      (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .pt_wr_en    (pt_wr_en),
    .pt_wr_addr  (pt_wr_addr),
    .pt_wr_time  (pt_wr_time),
    .pt_wr_sample(pt_wr_sample),
    .num_pts     (num_pts),
    .start       (start),
    .busy        (busy),
    .err         (err),
    .state_dbg   (state_dbg),
    .dma         (dma_if)
  );

  // Scoreboard: {last, data} per expected beat
  logic [48:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs0, done0;

  always @(posedge clk) begin
    if (dma_if.valid && dma_if.ready) hs_cnt <= hs_cnt + 1;
    if (dma_if.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic wr_pt(input logic [5:0] a, input logic [15:0] t, input logic [15:0] s);
    pt_wr_en = 1'b1; pt_wr_addr = a; pt_wr_time = t; pt_wr_sample = s;
    @(negedge clk);
    pt_wr_en = 1'b0;
  endtask

  task automatic go(input logic [6:0] n);
    start = 1'b1; num_pts = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int w = 0;
    while (!dma_if.valid && w < max) begin
      @(negedge clk);
      w++;
    end
    chk("valid_wait", dma_if.valid, 1);
  endtask

  // Assumes ready=1: each beat hands over on the posedge after it is seen.
  task automatic take_beats(input int n);
    logic [48:0] e;
    for (int b = 0; b < n; b++) begin
      wait_valid(40);
      e = exp_q.pop_front();
      chk("beat_data", dma_if.data, e[47:0]);
      chk("beat_last", dma_if.last, e[48]);
      @(negedge clk);
    end
  endtask

  task automatic halt_pulse();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  initial begin
    int seen;
    logic [6:0] bad_n [3];
    bad_n[0] = 7'd65; bad_n[1] = 7'd1; bad_n[2] = 7'd0;

    rst = 1'b1; halt = 1'b0; pt_wr_en = 1'b0; start = 1'b0;
    pt_wr_addr = '0; pt_wr_time = '0; pt_wr_sample = '0; num_pts = '0;
    dma_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", dma_if.valid, 0);
    chk("rst_last",  dma_if.last, 0);
    chk("rst_done",  dma_if.done, 0);
    chk("rst_data",  dma_if.data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_err",   err, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);

    // Three points, ready high: latency, beat format, last, done
    wr_pt(0, 16'd0, 16'd0); wr_pt(1, 16'd10, 16'd100); wr_pt(2, 16'd20, 16'd100);
    dma_if.ready = 1'b1;
    exp_q.push_back({1'b0, 48'h0000_0000_000A});
    exp_q.push_back({1'b0, 48'h000A_0064_0000});
    exp_q.push_back({1'b1, 48'h0014_0064_0000});
    hs0 = hs_cnt; done0 = done_cnt;
    go(3);
    chk("t1_busy", busy, 1);
    chk("t1_state_load", state_dbg, 1);
    repeat (16) @(negedge clk);
    chk("t1_valid_early", dma_if.valid, 0);
    @(negedge clk);
    chk("t1_valid_rise", dma_if.valid, 1);
    take_beats(3);
    chk("t1_done", dma_if.done, 1);
    chk("t1_busy_fin", busy, 0);
    @(negedge clk);
    chk("t1_done_once", dma_if.done, 0);
    chk("t1_idle", state_dbg, 0);
    chk("t1_hs", hs_cnt - hs0, 3);
    chk("t1_done_cnt", done_cnt - done0, 1);

    // Slope 2/3: truncates to 0, rounds to 1
    wr_pt(0, 16'd0, 16'd0); wr_pt(1, 16'd3, 16'd2);
`ifdef PWL_ROUND_SLOPE_EN
    exp_q.push_back({1'b0, 48'h0000_0000_0001});
`else
    exp_q.push_back({1'b0, 48'h0000_0000_0000});
`endif
    exp_q.push_back({1'b1, 48'h0003_0002_0000});
    go(2);
    take_beats(2);
    chk("t2_done", dma_if.done, 1);
    @(negedge clk);

    // Negative slope -1000/3 = -333
    wr_pt(0, 16'd0, 16'd1000); wr_pt(1, 16'd3, 16'd0);
    exp_q.push_back({1'b0, 48'h0000_03E8_FEB3});
    exp_q.push_back({1'b1, 48'h0003_0000_0000});
    go(2);
    take_beats(2);
    @(negedge clk);

    // Full-scale swing saturates to +32767
    wr_pt(0, 16'd0, 16'h8000); wr_pt(1, 16'd1, 16'h7FFF);
    exp_q.push_back({1'b0, 48'h0000_8000_7FFF});
    exp_q.push_back({1'b1, 48'h0001_7FFF_0000});
    go(2);
    take_beats(2);
    @(negedge clk);

    // Back-pressure for 40 cycles; start while busy is ignored
    wr_pt(0, 16'd0, 16'd0); wr_pt(1, 16'd5, 16'd10);
    dma_if.ready = 1'b0;
    hs0 = hs_cnt; done0 = done_cnt;
    go(2);
    repeat (3) @(negedge clk);
    go(1);
    chk("t5_start_ignored_err", err, 0);
    chk("t5_start_ignored_busy", busy, 1);
    wait_valid(40);
    for (int k = 0; k < 40; k++) begin
      chk("t5_hold_data", dma_if.data, 48'h0000_0000_0002);
      chk("t5_hold_valid", dma_if.valid, 1);
      chk("t5_hold_last", dma_if.last, 0);
      @(negedge clk);
    end
    chk("t5_no_hs_yet", hs_cnt - hs0, 0);
    dma_if.ready = 1'b1;
    @(negedge clk);
    chk("t5_first_hs", hs_cnt - hs0, 1);
    exp_q.push_back({1'b1, 48'h0005_000A_0000});
    take_beats(1);
    chk("t5_done", dma_if.done, 1);
    @(negedge clk);
    chk("t5_hs_total", hs_cnt - hs0, 2);
    chk("t5_done_cnt", done_cnt - done0, 1);

    // Non-increasing time at the second segment
    wr_pt(0, 16'd0, 16'd0); wr_pt(1, 16'd5, 16'd5); wr_pt(2, 16'd5, 16'd9);
    hs0 = hs_cnt; done0 = done_cnt;
    exp_q.push_back({1'b0, 48'h0000_0000_0001});
    go(3);
    take_beats(1);
    @(negedge clk);
    chk("t6_err", err, 1);
    chk("t6_busy", busy, 0);
    chk("t6_idle", state_dbg, 0);
    repeat (5) @(negedge clk);
    chk("t6_hs", hs_cnt - hs0, 1);
    chk("t6_no_done", done_cnt - done0, 0);

    // Halt mid-SEND: valid drops, err kept clear, no done
    wr_pt(0, 16'd0, 16'd0); wr_pt(1, 16'd5, 16'd10);
    dma_if.ready = 1'b0;
    hs0 = hs_cnt; done0 = done_cnt;
    go(2);
    chk("t7_err_cleared", err, 0);
    wait_valid(40);
    halt_pulse();
    chk("t7_valid", dma_if.valid, 0);
    chk("t7_last", dma_if.last, 0);
    chk("t7_busy", busy, 0);
    chk("t7_idle", state_dbg, 0);
    chk("t7_err", err, 0);
    repeat (3) @(negedge clk);
    chk("t7_no_done", done_cnt - done0, 0);
    chk("t7_no_hs", hs_cnt - hs0, 0);

    // Bad point counts: err set, no beats
    foreach (bad_n[j]) begin
      go(2);
      chk("t8_err_clear", err, 0);
      halt_pulse();
      go(bad_n[j]);
      chk("t8_err", err, 1);
      chk("t8_busy", busy, 0);
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (dma_if.valid) seen++;
      end
      chk("t8_no_valid", seen, 0);
    end

    // Asynchronous reset mid-SEND
    dma_if.ready = 1'b0;
    go(2);
    wait_valid(40);
    #2 rst = 1'b1;
    #1;
    chk("t9_valid", dma_if.valid, 0);
    chk("t9_busy", busy, 0);
    chk("t9_state", state_dbg, 0);
    chk("t9_data", dma_if.data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t9_err", err, 0);
    chk("t9_still_idle", dma_if.valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
